// File: rtl/mac_conventional_sequencer.sv
// mac_conventional_sequencer: streams (w, a) operand pairs into one MAC
// instance, waits out the MAC pipeline after the last element, then presents
// the accumulated dot product on a valid/ready result port.
// Optional build macro: MAC_SEQ_OVF_DETECT_EN enables the sticky
// accumulator overflow-risk flag reported on out_ovf; when it is undefined
// out_ovf is tied low.
module mac_conventional_sequencer #(
    parameter  int W_WIDTH     = 8,
    parameter  int A_WIDTH     = 8,
    parameter  int PLUS_WIDTH  = 4,
    parameter  int MAC_LATENCY = 2,
    parameter  int LEN_WIDTH   = 16,
    localparam int Z_WIDTH     = W_WIDTH + A_WIDTH + PLUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W_WIDTH-1:0]   in_w,
    input  logic [A_WIDTH-1:0]   in_a,
    input  logic                 in_last,
    output logic                 mac_rst,
    output logic                 mac_accu_rst,
    output logic [W_WIDTH-1:0]   mac_w,
    output logic [A_WIDTH-1:0]   mac_a,
    input  logic [Z_WIDTH-1:0]   mac_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [Z_WIDTH-1:0]   out_z,
    output logic [LEN_WIDTH-1:0] out_len,
    output logic                 out_ovf
);

    typedef enum logic [2:0] {
        S_RESET,
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_HOLD
    } state_t;

    // All registered state of the block; every output is a field of this.
    typedef struct packed {
        state_t                 state;
        logic                   in_ready;
        logic                   mac_rst;
        logic                   mac_accu_rst;
        logic [W_WIDTH-1:0]     mac_w;
        logic [A_WIDTH-1:0]     mac_a;
        logic                   out_valid;
        logic [Z_WIDTH-1:0]     out_z;
        logic [LEN_WIDTH-1:0]   out_len;
        logic [LEN_WIDTH-1:0]   cnt;
        logic [3:0]             dcnt;
`ifdef MAC_SEQ_OVF_DETECT_EN
        logic                   ovf;
        logic                   out_ovf;
`endif
    } seq_regs_t;

    localparam logic [3:0]           DRAIN_INIT = 4'(MAC_LATENCY);
    localparam logic [LEN_WIDTH-1:0] CNT_FIRST  = LEN_WIDTH'(1);
`ifdef MAC_SEQ_OVF_DETECT_EN
    // Above this many elements the guard bits no longer cover the sum.
    localparam int unsigned OVF_LIMIT = 32'd1 << PLUS_WIDTH;
`endif

    seq_regs_t r, r_nxt;

    logic                 xfer;
    logic [LEN_WIDTH-1:0] cnt_inc;

    assign xfer    = in_valid & r.in_ready;
    assign cnt_inc = (&r.cnt) ? r.cnt : r.cnt + 1'b1;

    // State register; reset drops any partial vector and any held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r         <= '0;
            r.state   <= S_RESET;
            r.mac_rst <= 1'b1;
        end else begin
            r <= r_nxt;
        end
    end

    // Next-state and next-output logic; the MAC sees zero operands unless a
    // transfer happens, so idle and drain cycles add nothing.
    always_comb begin
        r_nxt              = r;
        r_nxt.mac_w        = '0;
        r_nxt.mac_a        = '0;
        r_nxt.mac_accu_rst = 1'b0;
        case (r.state)
            S_RESET: begin
                r_nxt.mac_rst  = 1'b0;
                r_nxt.in_ready = 1'b1;
                r_nxt.state    = S_IDLE;
            end
            S_IDLE, S_ACCUM: begin
                if (xfer) begin
                    r_nxt.mac_w        = in_w;
                    r_nxt.mac_a        = in_a;
                    r_nxt.mac_accu_rst = (r.state == S_IDLE);
                    r_nxt.cnt          = (r.state == S_IDLE) ? CNT_FIRST : cnt_inc;
`ifdef MAC_SEQ_OVF_DETECT_EN
                    r_nxt.ovf = ((r.state == S_IDLE) ? 1'b0 : r.ovf)
                              | (32'(r_nxt.cnt) > OVF_LIMIT);
`endif
                    if (in_last) begin
                        r_nxt.in_ready = 1'b0;
                        r_nxt.dcnt     = DRAIN_INIT;
                        r_nxt.state    = S_DRAIN;
                    end else begin
                        r_nxt.state    = S_ACCUM;
                    end
                end
            end
            S_DRAIN: begin
                if (r.dcnt == 4'd0) begin
                    r_nxt.out_z     = mac_z;
                    r_nxt.out_len   = r.cnt;
                    r_nxt.out_valid = 1'b1;
`ifdef MAC_SEQ_OVF_DETECT_EN
                    r_nxt.out_ovf   = r.ovf;
`endif
                    r_nxt.state     = S_HOLD;
                end else begin
                    r_nxt.dcnt = r.dcnt - 4'd1;
                end
            end
            S_HOLD: begin
                if (r.out_valid && out_ready) begin
                    r_nxt.out_valid = 1'b0;
                    r_nxt.in_ready  = 1'b1;
                    r_nxt.state     = S_IDLE;
                end
            end
            default: begin
                r_nxt.state = S_RESET;
            end
        endcase
    end

    assign in_ready     = r.in_ready;
    assign mac_rst      = r.mac_rst;
    assign mac_accu_rst = r.mac_accu_rst;
    assign mac_w        = r.mac_w;
    assign mac_a        = r.mac_a;
    assign out_valid    = r.out_valid;
    assign out_z        = r.out_z;
    assign out_len      = r.out_len;
`ifdef MAC_SEQ_OVF_DETECT_EN
    assign out_ovf      = r.out_ovf;
`else
    assign out_ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_mac_conventional_sequencer.sv
// Directed bench for mac_conventional_sequencer with a behavioural
// two-cycle MAC attached to the MAC-side ports.
module tb_mac_conventional_sequencer;

    localparam int W  = 8;
    localparam int A  = 8;
    localparam int P  = 4;
    localparam int L  = 2;
    localparam int LW = 16;
    localparam int Z  = W + A + P;
`ifdef MAC_SEQ_OVF_DETECT_EN
    localparam int EXP_OVF = 1;
`else
    localparam int EXP_OVF = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_last;
    logic [W-1:0]  in_w;
    logic [A-1:0]  in_a;
    logic          mac_rst, mac_accu_rst;
    logic [W-1:0]  mac_w;
    logic [A-1:0]  mac_a;
    logic [Z-1:0]  mac_z;
    logic          out_valid, out_ready, out_ovf;
    logic [Z-1:0]  out_z;
    logic [LW-1:0] out_len;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int e0     = 0;

    mac_conventional_sequencer #(
        .W_WIDTH(W), .A_WIDTH(A), .PLUS_WIDTH(P), .MAC_LATENCY(L), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w), .in_a(in_a), .in_last(in_last),
        .mac_rst(mac_rst), .mac_accu_rst(mac_accu_rst), .mac_w(mac_w), .mac_a(mac_a), .mac_z(mac_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_len(out_len), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural MAC: one product stage, then the accumulator (latency 2).
    logic signed [Z-1:0] prod, p1, z_acc;
    logic                r1;
    assign prod  = $signed(mac_w) * $signed({1'b0, mac_a});
    assign mac_z = z_acc;
    always @(posedge clk) begin
        if (mac_rst) begin
            p1    <= '0;
            r1    <= 1'b0;
            z_acc <= '0;
        end else begin
            p1    <= prod;
            r1    <= mac_accu_rst;
            z_acc <= r1 ? p1 : z_acc + p1;
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic push(input int w, input int a, input logic last);
        int t;
        in_w     = W'(w);
        in_a     = A'(a);
        in_last  = last;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("push_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        e0       = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_res(input string tag, input longint ez, input longint elen,
                            input longint eovf);
        int t;
        t = 0;
        while (!out_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_lat"}, cyc - e0, L + 1);
        chk({tag, "_z"}, $signed(out_z), ez);
        chk({tag, "_len"}, out_len, elen);
        chk({tag, "_ovf"}, out_ovf, eovf);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_mac_rst"}, mac_rst, 1);
        chk({tag, "_accu_rst"}, mac_accu_rst, 0);
        chk({tag, "_mac_w"}, mac_w, 0);
        chk({tag, "_mac_a"}, mac_a, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_z"}, out_z, 0);
        chk({tag, "_out_len"}, out_len, 0);
        chk({tag, "_out_ovf"}, out_ovf, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_w = '0; in_a = '0; out_ready = 1'b1;
        #12;
        chk_reset_vals("rst0");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_rel_mac_rst_hi", mac_rst, 1);
        @(negedge clk);
        chk("rst_rel_mac_rst_lo", mac_rst, 0);
        chk("rst_rel_in_ready", in_ready, 1);

        // 3*2 - 1*5 + 4*10 = 41
        push(3, 2, 1'b0);
        chk("v1_accu_rst_first", mac_accu_rst, 1);
        push(-1, 5, 1'b0);
        chk("v1_accu_rst_second", mac_accu_rst, 0);
        chk("v1_mac_w", $signed(mac_w), -1);
        push(4, 10, 1'b1);
        chk("v1_drain_in_ready", in_ready, 0);
        wait_res("v1", 41, 3, 0);
        @(negedge clk);
        chk("v1_ack_valid", out_valid, 0);
        chk("v1_ack_in_ready", in_ready, 1);

        // -128 * 255 = -32640, single element from IDLE
        push(-128, 255, 1'b1);
        chk("v2_accu_rst", mac_accu_rst, 1);
        chk("v2_mac_w", $signed(mac_w), -128);
        chk("v2_mac_a", mac_a, 255);
        @(negedge clk);
        chk("v2_accu_rst_pulse", mac_accu_rst, 0);
        chk("v2_bubble_w", mac_w, 0);
        wait_res("v2", -32640, 1, 0);
        @(negedge clk);

        // Same vector with bubbles, result held under backpressure
        push(3, 2, 1'b0);
        @(negedge clk);
        push(-1, 5, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        push(4, 10, 1'b1);
        wait_res("v3", 41, 3, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("v3_hold_z", $signed(out_z), 41);
            chk("v3_hold_in_ready", in_ready, 0);
            chk("v3_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("v3_rel_valid", out_valid, 0);
        chk("v3_rel_in_ready", in_ready, 1);

        // Reset mid-ACCUM, then a clean (2,2) vector
        push(1, 1, 1'b0);
        push(5, 5, 1'b0);
        rst_n = 1'b0;
        #1 chk_reset_vals("rst1");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst1_rel_mac_rst_hi", mac_rst, 1);
        @(negedge clk);
        chk("rst1_rel_mac_rst_lo", mac_rst, 0);
        chk("rst1_rel_in_ready", in_ready, 1);
        push(2, 2, 1'b1);
        wait_res("v4", 4, 1, 0);
        @(negedge clk);

        // 17 elements exceed 2^PLUS_WIDTH, 16 do not
        for (int i = 0; i < 17; i++) push(1, 1, i == 16);
        wait_res("v5", 17, 17, EXP_OVF);
        @(negedge clk);
        for (int i = 0; i < 16; i++) push(1, 1, i == 15);
        wait_res("v6", 16, 16, 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
